// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - instruction memory reprogram controller
// Clears the whole imem, streams loader words in, then hands the memory port to fetch.
module imem_load_ctrl #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [31:0]   fetch_addr,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  output logic          cpu_hold,
  output logic          load_done,
  output logic [AW:0]   word_count,
  output logic          trunc_err,
  output logic          misalign
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_word_count;
  logic          r_trunc_err;

  logic w_accept;
  logic w_last_slot;
  logic w_clr_done;
  logic w_unused_fetch;

  assign w_accept    = (r_state == S_LOAD) && ld_valid;
  assign w_last_slot = (r_wptr == AW'(DEPTH - 1));
  assign w_clr_done  = (r_clr_cnt == AW'(DEPTH - 1));

  // Fetch addresses wrap modulo the memory size; upper PC bits are deliberately dropped.
  assign w_unused_fetch = ^fetch_addr[31:AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_clr_cnt    <= '0;
      r_wptr       <= '0;
      r_word_count <= '0;
      r_trunc_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state      <= S_CLEAR;
            r_clr_cnt    <= '0;
            r_word_count <= '0;
            r_trunc_err  <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + AW'(1);
          if (w_clr_done) begin
            r_state <= S_LOAD;
            r_wptr  <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_wptr       <= r_wptr + AW'(1);
            r_word_count <= r_word_count + (AW+1)'(1);
            if (ld_last || w_last_slot) begin
              r_state <= S_RUN;
            end
            // Memory full but the loader still has more program: flag the truncation.
            if (w_last_slot && !ld_last) begin
              r_trunc_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (load_start) begin
            r_state      <= S_CLEAR;
            r_clr_cnt    <= '0;
            r_word_count <= '0;
            r_trunc_err  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded straight from state so cpu_hold rises in the very cycle RUN is left.
  always_comb begin
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    misalign  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = r_clr_cnt;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        mem_addr = r_wptr;
        if (w_accept) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
        end
      end
      S_RUN: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        mem_addr  = fetch_addr[AW+1:2];
        misalign  = |fetch_addr[1:0];
      end
      default: ;
    endcase
  end

  assign word_count = r_word_count;
  assign trunc_err  = r_trunc_err;

endmodule
